// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 GPR file plus HI/LO pair committed from MEM/WB, two read ports and one HI/LO port.
// Define WB_BYPASS_EN to forward same-cycle writebacks straight to the read outputs.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_reg_write_en,
  input  logic [ADDR_W-1:0] wb_reg_addr,
  input  logic              wb_hilo_write_en,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data
);
  localparam int N = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [N];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic byp1, byp2, byp_hilo;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wb_reg_write_en && wb_reg_addr != '0) regs[wb_reg_addr] <= wb_data;
      if (wb_hilo_write_en) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
    end
`ifdef WB_BYPASS_EN
  assign byp1     = wb_reg_write_en && wb_reg_addr == rd1_addr;
  assign byp2     = wb_reg_write_en && wb_reg_addr == rd2_addr;
  assign byp_hilo = wb_hilo_write_en;
`else
  assign byp1     = 1'b0;
  assign byp2     = 1'b0;
  assign byp_hilo = 1'b0;
`endif
  // rst gates every output so an in-flight bypass cannot leak during reset
  always_comb begin
    rd1_data = (rst || !rd1_en || rd1_addr == '0) ? '0 : byp1 ? wb_data : regs[rd1_addr];
    rd2_data = (rst || !rd2_en || rd2_addr == '0) ? '0 : byp2 ? wb_data : regs[rd2_addr];
    hi_data  = rst ? '0 : byp_hilo ? wb_hi : hi_q;
    lo_data  = rst ? '0 : byp_hilo ? wb_lo : lo_q;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed test-plan cases plus randomized traffic against an array-based reference model.
module tb_wb_regfile;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] wb_data = '0, wb_hi = '0, wb_lo = '0;
  logic        wb_reg_write_en = 1'b0, wb_hilo_write_en = 1'b0;
  logic [4:0]  wb_reg_addr = '0, rd1_addr = '0, rd2_addr = '0;
  logic        rd1_en = 1'b0, rd2_en = 1'b0;
  logic [31:0] rd1_data, rd2_data, hi_data, lo_data;
  logic [31:0] mregs [32];
  logic [31:0] mhi, mlo;
  int n_tests = 0, n_fail = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_data(wb_data), .wb_reg_write_en(wb_reg_write_en),
    .wb_reg_addr(wb_reg_addr), .wb_hilo_write_en(wb_hilo_write_en), .wb_hi(wb_hi),
    .wb_lo(wb_lo), .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_data),
    .hi_data(hi_data), .lo_data(lo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic en, logic [4:0] a);
    if (rst || !en || a == 0) return '0;
    if (BYP && wb_reg_write_en && wb_reg_addr == a) return wb_data;
    return mregs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mhi = '0;
    mlo = '0;
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".rd1"}, rd1_data, exp_rd(rd1_en, rd1_addr));
    chk({tag, ".rd2"}, rd2_data, exp_rd(rd2_en, rd2_addr));
    chk({tag, ".hi"}, hi_data, rst ? 32'h0 : (BYP && wb_hilo_write_en) ? wb_hi : mhi);
    chk({tag, ".lo"}, lo_data, rst ? 32'h0 : (BYP && wb_hilo_write_en) ? wb_lo : mlo);
  endtask

  task automatic step(string tag);
    #1 check_outs(tag);
    @(posedge clk);
    if (!rst) begin
      if (wb_reg_write_en && wb_reg_addr != 0) mregs[wb_reg_addr] = wb_data;
      if (wb_hilo_write_en) begin
        mhi = wb_hi;
        mlo = wb_lo;
      end
    end
    #2;
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd, logic he, logic [31:0] h,
                       logic [31:0] l, logic e1, logic [4:0] a1, logic e2, logic [4:0] a2);
    wb_reg_write_en = we; wb_reg_addr = wa; wb_data = wd;
    wb_hilo_write_en = he; wb_hi = h; wb_lo = l;
    rd1_en = e1; rd1_addr = a1; rd2_en = e2; rd2_addr = a2;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    // reset clears contents and gates outputs
    drive(1, 5, 32'hDEADBEEF, 1, 32'h1, 32'h2, 1, 5, 1, 5);
    step("wr_r5");
    drive(1, 5, 32'h11111111, 1, 32'h33, 32'h44, 1, 5, 1, 5);
    #1 chk("pre_rst.r5", rd1_data, BYP ? 32'h11111111 : 32'hDEADBEEF);
    rst = 1'b1;
    #0.5;
    chk("in_rst.rd1", rd1_data, 32'h0);
    chk("in_rst.rd2", rd2_data, 32'h0);
    chk("in_rst.hi", hi_data, 32'h0);
    chk("in_rst.lo", lo_data, 32'h0);
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    #0.2 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst.r5", rd1_data, 32'h0);
    chk("post_rst.hi", hi_data, 32'h0);
    chk("post_rst.lo", lo_data, 32'h0);
    step("post_rst");
    // r0 protection
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0);
    #1 chk("r0.same", rd1_data, 32'h0);
    step("r0_wr");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 chk("r0.next", rd1_data, 32'h0);
    step("r0_rd");
    // same-cycle write/read of r7
    drive(1, 7, 32'h12345678, 0, 0, 0, 1, 7, 1, 7);
    #1 chk("r7.same1", rd1_data, BYP ? 32'h12345678 : 32'h0);
    chk("r7.same2", rd2_data, BYP ? 32'h12345678 : 32'h0);
    step("r7_wr");
    drive(0, 0, 0, 0, 0, 0, 1, 7, 1, 7);
    #1 chk("r7.next1", rd1_data, 32'h12345678);
    chk("r7.next2", rd2_data, 32'h12345678);
    step("r7_rd");
    // read enable gating
    drive(1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0);
    step("r3_wr");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    #1 chk("r3.dis", rd2_data, 32'h0);
    step("r3_dis");
    rd2_en = 1'b1;
    #1 chk("r3.en", rd2_data, 32'hA5A5A5A5);
    step("r3_en");
    // simultaneous GPR and HI/LO writes
    drive(1, 31, 32'h100, 1, 32'hCAFE0000, 32'h0000BEEF, 0, 0, 0, 0);
    step("sim_wr");
    drive(0, 0, 0, 0, 0, 0, 1, 31, 0, 0);
    #1 chk("sim.r31", rd1_data, 32'h100);
    chk("sim.hi", hi_data, 32'hCAFE0000);
    chk("sim.lo", lo_data, 32'h0000BEEF);
    step("sim_rd");
    // disabled write enable
    drive(1, 9, 32'h77, 0, 0, 0, 0, 0, 0, 0);
    step("r9_wr");
    drive(0, 9, 32'h55, 0, 0, 0, 1, 9, 0, 0);
    step("r9_off");
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    #1 chk("r9.keep", rd1_data, 32'h77);
    step("r9_rd");
    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 3) == 0, $urandom, $urandom,
            $urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #0.5 check_outs("rnd_rst");
        model_clear();
        #0.2 rst = 1'b0;
      end
      step("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline bundle: holds the 32×32-bit general register file and the HI/LO register pair. It commits the `data`/`reg_write_en`/`reg_addr` and `hilo_write_en`/`hi`/`lo` fields delivered by the MEM/WB register. It serves two general-register read ports and one HI/LO read port to the ID and EX stages. Same-cycle write-to-read forwarding is compile-time selectable.

## Interface
Parameters:
- `DATA_W`, 32, register width (equals `DataBusWidth`)
- `ADDR_W`, 5, register address width (equals `RegAddrBusWidth`)

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `wb_data`  input  DATA_W  writeback data from MEM/WB
- `wb_reg_write_en`  input  1  commit `wb_data` to `wb_reg_addr`
- `wb_reg_addr`  input  ADDR_W  destination register
- `wb_hilo_write_en`  input  1  commit `wb_hi`/`wb_lo`
- `wb_hi`  input  DATA_W  HI writeback value
- `wb_lo`  input  DATA_W  LO writeback value
- `rd1_en`  input  1  read port 1 enable
- `rd1_addr`  input  ADDR_W  read port 1 address
- `rd1_data`  output  DATA_W  read port 1 data
- `rd2_en`  input  1  read port 2 enable
- `rd2_addr`  input  ADDR_W  read port 2 address
- `rd2_data`  output  DATA_W  read port 2 data
- `hi_data`  output  DATA_W  current HI
- `lo_data`  output  DATA_W  current LO

## Operation
- Storage: `regs[0..31]`, `hi_q`, `lo_q`. On `rst` high, all are cleared to 0 immediately, independent of `clk`.
- General write: on a rising edge with `rst` low and `wb_reg_write_en`=1 and `wb_reg_addr`≠0, `regs[wb_reg_addr]` ← `wb_data`. A write to address 0 is discarded.
- HI/LO write: on a rising edge with `wb_hilo_write_en`=1, `hi_q` ← `wb_hi` and `lo_q` ← `wb_lo` together. There is no partial HI/LO write.
- General and HI/LO writes are independent and may occur in the same cycle.
- Read ports are combinational. Each port has the following priority:
  1. `rdN_en`=0 → 0.
  2. `rdN_addr`=0 → 0. Register 0 reads zero even while a writeback to it is pending.
  3. Bypass hit (see Configuration) → `wb_data`.
  4. Otherwise → `regs[rdN_addr]`.
- Both read ports may address the same register. Both then return an identical value.
- `hi_data`/`lo_data`: bypassed `wb_hi`/`wb_lo` when `wb_hilo_write_en`=1 and bypass is enabled. Otherwise `hi_q`/`lo_q`.
- The block has no stall input. MEM/WB already converts stalls into bubbles (write enables low), so every asserted enable commits exactly once.

## Timing
- Write latency: one edge. Data presented in cycle N is held in storage from cycle N+1.
- Read latency: zero cycles (combinational from address/enable to data).
- Reset:
  - During reset, every output is 0 regardless of inputs. The bypass path is gated by `rst`.
  - Outputs return to storage/bypass values in the first cycle after deassertion.
  - A write whose edge coincides with `rst` high is lost.
- Reset asserted mid-operation: register contents are lost. No writeback is replayed.

## Configuration
- `WB_BYPASS_EN` defined:
  - `rdN_data` = `wb_data` when `wb_reg_write_en`=1, `wb_reg_addr`=`rdN_addr`≠0 and `rdN_en`=1.
  - HI/LO are bypassed likewise.
  - A writeback-stage producer is then visible to ID in the same cycle, so no extra forwarding path or stall is needed for WB→ID distance.
- Not defined: reads always return stored values. A same-cycle read of the register being written returns the old value, and the new value appears from N+1. Hazard logic must cover the WB→ID distance.

## Test plan
- Reset:
  - Write 0xDEADBEEF to r5 and HI/LO=1/2, then pulse `rst` between clock edges.
  - Outputs are 0 immediately. Reading r5 after release returns 0, and `hi_data`/`lo_data` are 0.
- r0 protection:
  - Write 0xFFFFFFFF to r0 with `wb_reg_write_en`=1, with port 1 reading r0 in the same and the next cycle.
  - `rd1_data`=0 in both cycles.
- Same-cycle write/read of r7 = 0x12345678, both ports reading r7, previous value 0x0:
  - With `WB_BYPASS_EN`: both ports read 0x12345678 in the same cycle.
  - Without `WB_BYPASS_EN`: both ports read 0x0 in the write cycle and 0x12345678 on the next cycle.
- Read enable gating: write r3=0xA5A5A5A5, then set `rd2_en`=0 with `rd2_addr`=3 → `rd2_data`=0. Setting `rd2_en`=1 gives 0xA5A5A5A5.
- Simultaneous writes: in one cycle, write r31=0x100 and HI/LO=0xCAFE0000/0x0000BEEF. The next cycle reads 0x100, 0xCAFE0000 and 0x0000BEEF.
- Disabled enable: with `wb_reg_write_en`=0, `wb_reg_addr`=9 and `wb_data`=0x55, r9 keeps its prior value 0x77.
